// File: rtl/set_dispatch_pkg.sv
// Shared types and widths for the SET job dispatcher.
package set_dispatch_pkg;

    localparam int unsigned COORD_W   = 4;
    localparam int unsigned CENTRAL_W = 6 * COORD_W;
    localparam int unsigned RADIUS_W  = 3 * COORD_W;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned CAND_W    = 8;
    localparam int unsigned SEQ_W     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StEn,
        StWait,
        StOut
    } state_e;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } job_t;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO; flags derive from a registered occupancy count.
module set_job_fifo
    import set_dispatch_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  job_t wdata_i,
    input  logic pop_i,
    output job_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

    job_t            mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/set_dispatch.sv
// Dispatches queued jobs to the SET engine one at a time and returns tagged results.
// Define SET_DISPATCH_TIMEOUT_EN to add a WAIT watchdog that abandons a job after TIMEOUT cycles.
module set_dispatch
    import set_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CENTRAL_W-1:0] job_central,
    input  logic [RADIUS_W-1:0]  job_radius,
    input  logic [MODE_W-1:0]    job_mode,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [MODE_W-1:0]    set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CAND_W-1:0]    res_candidate,
    output logic [MODE_W-1:0]    res_mode,
    output logic [SEQ_W-1:0]     res_seq,
    output logic                 res_timeout,
    output logic                 idle
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
        $error("set_dispatch: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT nonzero");
    end

    state_e           state_q, state_d;
    job_t             job_in, fifo_head, issue_q;
    logic             fifo_full, fifo_empty;
    logic             pop, capture, cap_timeout, wait_expired;
    logic [SEQ_W-1:0] issue_cnt_q, seq_q;
    logic [CAND_W-1:0] res_cand_q;
    logic [MODE_W-1:0] res_mode_q;
    logic [SEQ_W-1:0]  res_seq_q;
    logic              res_to_q;

    assign job_in = {job_central, job_radius, job_mode};

    set_job_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (job_valid),
        .wdata_i (job_in),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SET_DISPATCH_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    logic [WaitW-1:0] wait_cnt_q;

    // Counter holds k during the k-th WAIT cycle; expiry fires in the cycle it would reach TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == StEn) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign wait_expired = (state_q == StWait) && (wait_cnt_q == WaitLast);
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        cap_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !set_busy) begin
                    pop     = 1'b1;
                    state_d = StEn;
                end
            end
            StEn: state_d = StWait;
            StWait: begin
                // A real result beats the watchdog when both land together.
                if (set_valid) begin
                    capture = 1'b1;
                    state_d = StOut;
                end else if (wait_expired) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    state_d     = StOut;
                end
            end
            StOut: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_q     <= '0;
            issue_cnt_q <= '0;
            seq_q       <= '0;
            res_cand_q  <= '0;
            res_mode_q  <= '0;
            res_seq_q   <= '0;
            res_to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                issue_q     <= fifo_head;
                seq_q       <= issue_cnt_q;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (capture) begin
                res_cand_q <= cap_timeout ? '0 : set_candidate;
                res_mode_q <= issue_q.mode;
                res_seq_q  <= seq_q;
                res_to_q   <= cap_timeout;
            end
        end
    end

    assign job_ready     = !fifo_full;
    assign set_en        = (state_q == StEn);
    assign set_central   = issue_q.central;
    assign set_radius    = issue_q.radius;
    assign set_mode      = issue_q.mode;
    assign res_valid     = (state_q == StOut);
    assign res_candidate = res_cand_q;
    assign res_mode      = res_mode_q;
    assign res_seq       = res_seq_q;
    assign res_timeout   = res_to_q;
    assign idle          = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_set_dispatch.sv
// Self-checking bench for set_dispatch with a behavioural SET engine model and scoreboard.
module tb_set_dispatch;
    import set_dispatch_pkg::*;

    typedef struct packed {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic [7:0]  cand;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic [23:0] job_central = '0;
    logic [11:0] job_radius = '0;
    logic [1:0]  job_mode = '0;
    logic        res_ready = 1'b1;
    logic        job_ready, set_en, set_busy, set_valid, res_valid, res_timeout, idle;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode, res_mode;
    logic [7:0]  set_candidate, res_candidate, res_seq;

    // SET engine model controls
    logic        m_busy = 1'b0, m_valid = 1'b0, m_never = 1'b0;
    logic        force_busy = 1'b0, inj_valid = 1'b0;
    logic [7:0]  m_cand = '0, inj_cand = '0;
    int          m_cnt = 0, m_delay = 2;

    int          checks = 0, errors = 0, en_cnt = 0, res_cnt = 0;
    logic        sb_en = 1'b1;
    logic [7:0]  exp_seq = '0;
    job_t        jq[$];
    job_t        mon_job;
    vec_t        vt[7];

    always #5 clk = ~clk;

    assign set_busy      = m_busy | force_busy;
    assign set_valid     = m_valid | inj_valid;
    assign set_candidate = m_valid ? m_cand : inj_cand;

    set_dispatch #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_central   (job_central),
        .job_radius    (job_radius),
        .job_mode      (job_mode),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_candidate (res_candidate),
        .res_mode      (res_mode),
        .res_seq       (res_seq),
        .res_timeout   (res_timeout),
        .idle          (idle)
    );

    // Circle coverage on the 8x8 grid (1..8): 0 A, 1 A&B, 2 A^B, 3 exactly two of A,B,C.
    function automatic logic [7:0] cov(input logic [23:0] c, input logic [11:0] r,
                                       input logic [1:0] m);
        int n, xa, ya, xb, yb, xc, yc, ra, rb, rc, a, b, k, hit;
        n = 0;
        xa = int'(c[23:20]); ya = int'(c[19:16]); xb = int'(c[15:12]);
        yb = int'(c[11:8]);  xc = int'(c[7:4]);   yc = int'(c[3:0]);
        ra = int'(r[11:8]);  rb = int'(r[7:4]);   rc = int'(r[3:0]);
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                a = ((x - xa) * (x - xa) + (y - ya) * (y - ya) <= ra * ra) ? 1 : 0;
                b = ((x - xb) * (x - xb) + (y - yb) * (y - yb) <= rb * rb) ? 1 : 0;
                k = ((x - xc) * (x - xc) + (y - yc) * (y - yc) <= rc * rc) ? 1 : 0;
                case (m)
                    2'd0:    hit = a;
                    2'd1:    hit = a & b;
                    2'd2:    hit = a ^ b;
                    default: hit = (a + b + k == 2) ? 1 : 0;
                endcase
                n += hit;
            end
        end
        return 8'(n);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0;
        end else if (set_en) begin
            m_busy <= 1'b1;
            m_cnt  <= m_delay;
            m_cand <= cov(set_central, set_radius, set_mode);
        end else if (m_busy && !m_never) begin
            if (m_cnt == 0) begin
                m_valid <= 1'b1;
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Scoreboard: jobs are expected back in push order with consecutive 8-bit sequence numbers.
    always @(negedge clk) begin
        if (rst) begin
            jq.delete();
            exp_seq = '0;
        end else begin
            if (set_en) begin
                en_cnt++;
                chk("one_in_flight", {31'd0, m_busy | res_valid}, 32'd0);
            end
            if (job_valid && job_ready) begin
                mon_job.central = job_central;
                mon_job.radius  = job_radius;
                mon_job.mode    = job_mode;
                jq.push_back(mon_job);
            end
            if (res_valid && res_ready) begin
                res_cnt++;
                if (jq.size() == 0) begin
                    chk("sb_queue_size", 32'(jq.size()), 32'd1);
                end else begin
                    mon_job = jq.pop_front();
                    if (sb_en) begin
                        chk("sb_cand", {24'd0, res_candidate},
                            {24'd0, cov(mon_job.central, mon_job.radius, mon_job.mode)});
                        chk("sb_seq", {24'd0, res_seq}, {24'd0, exp_seq});
                        chk("sb_mode", {30'd0, res_mode}, {30'd0, mon_job.mode});
                        chk("sb_timeout", {31'd0, res_timeout}, 32'd0);
                    end
                end
                exp_seq = exp_seq + 8'd1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        job_valid = 1'b1;
        job_central = c;
        job_radius = r;
        job_mode = m;
        step();
        while (!job_ready && n < 500) begin
            step();
            n++;
        end
        if (!job_ready) chk("push_ready_timeout", {31'd0, job_ready}, 32'd1);
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!res_valid && n < 300);
        chk({nm, "_arrive"}, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic chk_res(input string nm, input logic [7:0] cand, input logic [1:0] m,
                           input logic [7:0] seq, input logic to);
        chk({nm, "_cand"}, {24'd0, res_candidate}, {24'd0, cand});
        chk({nm, "_mode"}, {30'd0, res_mode}, {30'd0, m});
        chk({nm, "_seq"}, {24'd0, res_seq}, {24'd0, seq});
        chk({nm, "_timeout"}, {31'd0, res_timeout}, {31'd0, to});
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_set_en"}, {31'd0, set_en}, 32'd0);
        chk({nm, "_set_data"}, {set_central, set_radius, set_mode} == '0 ? 32'd0 : 32'd1, 32'd0);
        chk({nm, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk_res(nm, 8'd0, 2'd0, 8'd0, 1'b0);
        chk({nm, "_job_ready"}, {31'd0, job_ready}, 32'd1);
        chk({nm, "_idle"}, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, n, rb;
        vt[0] = '{24'h440000, 12'h200, 2'd0, 8'd13};
        vt[1] = '{24'h440000, 12'h100, 2'd0, 8'd5};
        vt[2] = '{24'h110000, 12'h100, 2'd0, 8'd3};
        vt[3] = '{24'h444400, 12'h210, 2'd1, 8'd5};
        vt[4] = '{24'h444400, 12'h210, 2'd2, 8'd8};
        vt[5] = '{24'h444488, 12'h210, 2'd3, 8'd5};
        vt[6] = '{24'h880000, 12'h300, 2'd0, 8'd11};

        do_reset();
        step();
        chk_reset_vals("reset");

        // Single job: set_en one cycle after the pop, two after the push.
        push_job(vt[0].c, vt[0].r, vt[0].m);
        step();
        chk("t1_en_t", {31'd0, set_en}, 32'd0);
        chk("t1_idle", {31'd0, idle}, 32'd0);
        step();
        chk("t1_en_t1", {31'd0, set_en}, 32'd1);
        chk("t1_central", {8'd0, set_central}, {8'd0, vt[0].c});
        step();
        chk("t1_en_t2", {31'd0, set_en}, 32'd0);
        wait_res("t1");
        chk_res("t1", 8'd13, 2'd0, 8'd0, 1'b0);

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push_job(vt[i].c, vt[i].r, vt[i].m);
            wait_res("vec");
            chk_res("vec", vt[i].cand, vt[i].m, 8'(i), 1'b0);
        end

        // SET busy holds off the issue.
        @(posedge clk);
        #1 force_busy = 1'b1;
        push_job(vt[1].c, vt[1].r, vt[1].m);
        e0 = en_cnt;
        repeat (5) step();
        chk("busy_no_en", 32'(en_cnt - e0), 32'd0);
        chk("busy_not_idle", {31'd0, idle}, 32'd0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        wait_res("busy");
        chk("busy_one_en", 32'(en_cnt - e0), 32'd1);
        chk("busy_cand", {24'd0, res_candidate}, {24'd0, vt[1].cand});

        // Fill the FIFO while SET is stalled, then drain in order.
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_job(vt[i].c, vt[i].r, vt[i].m);
        step();
        chk("fifo_full_ready", {31'd0, job_ready}, 32'd0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        push_job(vt[4].c, vt[4].r, vt[4].m);
        for (int i = 0; i < 5; i++) begin
            wait_res("drain");
            chk("drain_seq", {24'd0, res_seq}, 32'(i));
            chk("drain_cand", {24'd0, res_candidate}, {24'd0, vt[i].cand});
        end

        // Result back-pressure
        do_reset();
        res_ready = 1'b0;
        push_job(vt[0].c, vt[0].r, vt[0].m);
        push_job(vt[5].c, vt[5].r, vt[5].m);
        wait_res("stall");
        e0 = en_cnt;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk_res("stall", vt[0].cand, vt[0].m, 8'd0, 1'b0);
        end
        chk("stall_no_en", 32'(en_cnt - e0), 32'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_res("stall2");
        chk_res("stall2", vt[5].cand, vt[5].m, 8'd1, 1'b0);

`ifdef SET_DISPATCH_TIMEOUT_EN
        // Watchdog: no result, then a result on the last WAIT cycle.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            sb_en   = 1'b0;
            m_never = (pass == 0);
            m_delay = 14;
            push_job(vt[0].c, vt[0].r, vt[0].m);
            n = 0;
            step();
            while (!set_en && n < 50) begin
                step();
                n++;
            end
            n = 0;
            do begin
                step();
                n++;
            end while (!res_valid && n < 100);
            chk("to_latency", 32'(n), 32'd17);
            chk_res("to", (pass == 0) ? 8'd0 : vt[0].cand, vt[0].m, 8'd0, pass == 0);
        end
        do_reset();
        m_never = 1'b0;
        m_delay = 2;
        sb_en   = 1'b1;
`endif

        // Reset in WAIT with jobs queued; a late set_valid must be ignored.
        do_reset();
        m_never = 1'b1;
        for (int i = 0; i < 3; i++) push_job(vt[i].c, vt[i].r, vt[i].m);
        repeat (3) step();
        chk("rst6_busy_idle", {31'd0, idle}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_never = 1'b0;
        step();
        chk_reset_vals("rst6");
        e0 = en_cnt;
        @(posedge clk);
        #1;
        inj_cand  = 8'h5a;
        inj_valid = 1'b1;
        @(posedge clk);
        #1 inj_valid = 1'b0;
        repeat (3) begin
            step();
            chk("rst6_no_res", {31'd0, res_valid}, 32'd0);
        end
        chk("rst6_no_en", 32'(en_cnt - e0), 32'd0);
        chk("rst6_idle", {31'd0, idle}, 32'd1);
        push_job(vt[3].c, vt[3].r, vt[3].m);
        wait_res("rst6");
        chk_res("rst6_after", vt[3].cand, vt[3].m, 8'd0, 1'b0);

        // Random traffic against the scoreboard; 260 jobs exercise the sequence wrap.
        do_reset();
        rb = res_cnt;
        n = 0;
        fork
            begin
                for (int i = 0; i < 260; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    push_job(24'($urandom), 12'($urandom), 2'($urandom));
                end
            end
            begin
                while (res_cnt - rb < 260 && n < 30000) begin
                    @(posedge clk);
                    #1;
                    res_ready  = ($urandom_range(0, 3) != 0);
                    m_delay    = int'($urandom_range(0, 5));
                    force_busy = ($urandom_range(0, 7) == 0);
                    n++;
                end
            end
        join
        chk("rand_results", 32'(res_cnt - rb), 32'd260);
        res_ready  = 1'b1;
        force_busy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_dispatch.md
# set_dispatch

Job dispatcher sitting directly upstream of the SET circle-coverage engine. Buffers incoming (central, radius, mode) jobs in a small FIFO, drives SET's en/busy/valid handshake one job at a time, captures each `candidate` result and returns it on a ready/valid result stream tagged with a sequence number. Replaces the bench-style "wait busy low, pulse en, wait valid" loop with synthesizable control so SET can be driven by a host or a pattern ROM.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: job FIFO entries; power of two, at least 2.
- `TIMEOUT`, 1023: maximum cycles in WAIT before the job is abandoned; used only with `SET_DISPATCH_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `job_valid` in 1: job offered.
- `job_ready` out 1: job FIFO can accept.
- `job_central` in 24: {xA,yA,xB,yB,xC,yC}, 4 bits each.
- `job_radius` in 12: {rA,rB,rC}, 4 bits each.
- `job_mode` in 2: SET mode, 0 to 3.
- `set_en` out 1: one-cycle start pulse to SET.
- `set_central` out 24: job central, held from en until result capture.
- `set_radius` out 12: job radius, held from en until result capture.
- `set_mode` out 2: job mode, held from en until result capture.
- `set_busy` in 1: SET busy.
- `set_valid` in 1: SET result valid.
- `set_candidate` in 8: SET result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_candidate` out 8: captured candidate.
- `res_mode` out 2: mode of the job.
- `res_seq` out 8: job sequence number.
- `res_timeout` out 1: job abandoned by the watchdog.
- `idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- Job push when `job_valid && job_ready`. `job_ready = !full`, computed from the registered count only, so a pop in the same cycle does not lift a full stall. Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: on `!empty && !set_busy`, pop the head into the issue registers, assign `seq` from the issue counter, increment the counter, then go to EN. If `set_busy` is high, stay in IDLE.
  - EN: `set_en=1` for exactly one cycle, then go to WAIT.
  - WAIT: on `set_valid`, latch `set_candidate` and go to OUT. `set_valid` seen in any other state is ignored.
  - OUT: `res_valid=1`. Outputs are stable until `res_ready`. On handshake, go to IDLE.
- Only one job is in flight at a time. No new `set_en` is issued while in WAIT or OUT.
- The issue counter is 8 bits and wraps from 255 to 0. Its reset value is 0.
- `set_central`, `set_radius` and `set_mode` change only on a pop.

## Timing
- Reset values: `set_en` 0, `set_*` data 0, `res_*` 0, `job_ready` 1, `idle` 1, FIFO empty, issue counter 0, FSM in IDLE.
- Job pushed into an empty FIFO at edge t, with `set_busy` low: pop at edge t+1 and `set_en` high during cycle t+1 to t+2.
- `set_valid` sampled high at edge v gives `res_valid` high from v onward.
- Back-to-back jobs: the next pop can occur at the edge after the `res_ready` handshake.
- `rst` asserted in any state clears everything on the next edge. A late `set_valid` from the abandoned job is ignored because the FSM is in IDLE.

## Configuration
- `SET_DISPATCH_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to WAIT and counts while in WAIT.
  - On reaching `TIMEOUT` without `set_valid`, go to OUT with `res_timeout=1` and `res_candidate=0`.
  - If `set_valid` arrives in the same cycle the counter reaches `TIMEOUT`, `set_valid` wins and `res_timeout=0`.
- Undefined: WAIT waits indefinitely, no counter logic is generated, and `res_timeout` is tied to 0.

## Structure
- Package `set_dispatch_pkg`:
  - FSM state enum: IDLE, EN, WAIT, OUT.
  - Width constants: `COORD_W=4`, `CENTRAL_W=24`, `RADIUS_W=12`, `MODE_W=2`, `CAND_W=8`, `SEQ_W=8`.
  - Packed job struct {central, radius, mode}.
- Sub-module `set_job_fifo`: synchronous FIFO of job structs with full/empty flags and a registered count. The top module holds the FSM, issue registers and result registers.

## Test plan
Use a behavioural SET model with programmable busy/valid delays.
1. Single job, mode 0, central 24'h440000, radius 12'h200 (A at (4,4), r=2) -> `set_en` high 1 cycle after the pop, `res_candidate`=13, `res_seq`=0, `res_mode`=0.
2. `set_busy` held high 5 cycles with one job queued -> no `set_en` during busy; exactly one `set_en` pulse after busy falls.
3. Five jobs pushed back-to-back with `FIFO_DEPTH`=4 and SET stalled -> `job_ready` low after 4 accepts; results return in order with `res_seq` 0,1,2,3,4.
4. `res_ready` held low 10 cycles -> `res_valid` and all `res_*` fields stable; no `set_en` during the stall.
5. With `SET_DISPATCH_TIMEOUT_EN` and `TIMEOUT`=16, model never asserts valid -> OUT after 16 WAIT cycles with `res_timeout`=1 and `res_candidate`=0. Repeat with valid on cycle 16 -> `res_timeout`=0 and the real candidate.
6. `rst` pulsed while in WAIT with 2 jobs queued, late `set_valid` two cycles after -> all outputs at reset values, no result emitted, next job gets `res_seq`=0.
